// File: rtl/writeback_stage_inner_if.sv
// Pipeline link between the memory stage (master) and the writeback stage (slave).
// Handshake: a transfer happens on a posedge when status_forwards_in[0] (valid) and
// status_backwards_out[0] (ready) are both 1; bit 1 of status_backwards_out flushes upstream.
interface writeback_stage_inner_if;
  logic [3:0]  status_forwards_in;
  logic [1:0]  status_backwards_out;
  logic [31:0] rd_data_in;
  logic [31:0] source_data_in;
  logic [64:0] instruction_in;
  logic [31:0] program_counter_in;
  logic [31:0] next_program_counter_in;

  modport master (
    output status_forwards_in,
    output rd_data_in,
    output source_data_in,
    output instruction_in,
    output program_counter_in,
    output next_program_counter_in,
    input  status_backwards_out
  );

  modport slave (
    input  status_forwards_in,
    input  rd_data_in,
    input  source_data_in,
    input  instruction_in,
    input  program_counter_in,
    input  next_program_counter_in,
    output status_backwards_out
  );
endinterface

// File: rtl/writeback_stage_inner.sv
// Final pipeline stage: load alignment, register-file write, forwarding,
// precise trap sequencing (mepc/mcause + redirect) and cycle/instret counters.
module writeback_stage_inner #(
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter int          COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  writeback_stage_inner_if.slave   pipe,
  output logic                     rf_we,
  output logic [4:0]               rf_rd_addr,
  output logic [31:0]              rf_rd_data,
  output logic [37:0]              forwarding_out,
  output logic [31:0]              jump_address_backwards_out,
  output logic [31:0]              mepc_out,
  output logic [1:0]               mcause_out,
  output logic [COUNTER_WIDTH-1:0] cycle_count_out,
  output logic [COUNTER_WIDTH-1:0] instret_count_out,
  output logic                     state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  logic        in_valid;
  logic        in_exception;
  logic [1:0]  in_cause;
  logic [4:0]  in_rd;
  logic        in_writes_rd;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_offset;
  logic        ready;
  logic        accept;
  logic        retire;
  logic        take_trap;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] wb_data;

  // Fields outside the decoded subset and the trace-only next PC are not consumed here.
  logic unused_inputs;
  assign unused_inputs = ^{pipe.instruction_in[64:10], pipe.next_program_counter_in,
                           pipe.source_data_in[31:2]};

  assign in_valid     = pipe.status_forwards_in[0];
  assign in_exception = pipe.status_forwards_in[1];
  assign in_cause     = pipe.status_forwards_in[3:2];
  assign in_rd        = pipe.instruction_in[4:0];
  assign in_writes_rd = pipe.instruction_in[5];
  assign in_is_load   = pipe.instruction_in[6];
  assign in_funct3    = pipe.instruction_in[9:7];
  assign in_offset    = pipe.source_data_in[1:0];

  assign ready     = (state == IDLE);
  assign accept    = in_valid && ready;
  assign retire    = accept && !in_exception;
  assign take_trap = accept && in_exception;

  // Load data extraction; misaligned accesses never reach this point.
  assign load_byte = pipe.rd_data_in[{in_offset, 3'b000} +: 8];
  assign load_half = pipe.rd_data_in[{in_offset[1], 4'b0000} +: 16];

  always_comb begin
    wb_data = pipe.rd_data_in;
    if (in_is_load) begin
      case (in_funct3)
        3'b000:  wb_data = {{24{load_byte[7]}}, load_byte};
        3'b100:  wb_data = {24'h0, load_byte};
        3'b001:  wb_data = {{16{load_half[15]}}, load_half};
        3'b101:  wb_data = {16'h0, load_half};
        default: wb_data = pipe.rd_data_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next                 = state;
    jump_address_backwards_out = 32'h0;
    pipe.status_backwards_out  = 2'b01;
    case (state)
      IDLE: begin
        if (take_trap) begin
          state_next = TRAP;
        end
      end
      TRAP: begin
        // Single redirect cycle; anything upstream presents now is being flushed.
        state_next                 = IDLE;
        jump_address_backwards_out = TRAP_VECTOR;
        pipe.status_backwards_out  = 2'b10;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= 5'h0;
      rf_rd_data <= 32'h0;
    end else if (retire) begin
      rf_we      <= in_writes_rd && (in_rd != 5'h0);
      rf_rd_addr <= in_rd;
      rf_rd_data <= wb_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_out   <= 32'h0;
      mcause_out <= 2'b00;
    end else if (take_trap) begin
      mepc_out   <= pipe.program_counter_in;
      mcause_out <= in_cause;
    end
  end

  // Counters wrap naturally at 2^COUNTER_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_out   <= '0;
      instret_count_out <= '0;
    end else begin
      cycle_count_out <= cycle_count_out + CNT_ONE;
      if (retire) begin
        instret_count_out <= instret_count_out + CNT_ONE;
      end
    end
  end

  assign forwarding_out = {rf_we, rf_rd_addr, rf_rd_data};
  assign state_dbg      = state;

endmodule

// File: tb/tb_writeback_stage_inner.sv
// Directed bench for writeback_stage_inner: table of single-instruction retires
// followed by hand-written reset, back-to-back, trap and counter-wrap sequences.
module tb_writeback_stage_inner;

  logic clk;
  logic rst;

  writeback_stage_inner_if pipe ();
  writeback_stage_inner_if pipe_s ();

  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [37:0] forwarding_out;
  logic [31:0] jump_addr;
  logic [31:0] mepc;
  logic [1:0]  mcause;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic        state_dbg;

  logic        s_rf_we;
  logic [4:0]  s_rf_rd_addr;
  logic [31:0] s_rf_rd_data;
  logic [37:0] s_forwarding_out;
  logic [31:0] s_jump_addr;
  logic [31:0] s_mepc;
  logic [1:0]  s_mcause;
  logic [3:0]  s_cycle_cnt;
  logic [3:0]  s_instret_cnt;
  logic        s_state_dbg;

  writeback_stage_inner dut (
    .clk                        (clk),
    .rst                        (rst),
    .pipe                       (pipe.slave),
    .rf_we                      (rf_we),
    .rf_rd_addr                 (rf_rd_addr),
    .rf_rd_data                 (rf_rd_data),
    .forwarding_out             (forwarding_out),
    .jump_address_backwards_out (jump_addr),
    .mepc_out                   (mepc),
    .mcause_out                 (mcause),
    .cycle_count_out            (cycle_cnt),
    .instret_count_out          (instret_cnt),
    .state_dbg                  (state_dbg)
  );

  writeback_stage_inner #(.COUNTER_WIDTH(4)) dut_small (
    .clk                        (clk),
    .rst                        (rst),
    .pipe                       (pipe_s.slave),
    .rf_we                      (s_rf_we),
    .rf_rd_addr                 (s_rf_rd_addr),
    .rf_rd_data                 (s_rf_rd_data),
    .forwarding_out             (s_forwarding_out),
    .jump_address_backwards_out (s_jump_addr),
    .mepc_out                   (s_mepc),
    .mcause_out                 (s_mcause),
    .cycle_count_out            (s_cycle_cnt),
    .instret_count_out          (s_instret_cnt),
    .state_dbg                  (s_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  logic [63:0] exp_instret;

  typedef struct {
    logic [2:0]  funct3;
    logic        is_load;
    logic        writes_rd;
    logic [4:0]  rd;
    logic [31:0] raw;
    logic [1:0]  off;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pipe.status_forwards_in      = 4'b0000;
    pipe.rd_data_in              = 32'h0;
    pipe.source_data_in          = 32'h0;
    pipe.instruction_in          = '0;
    pipe.program_counter_in      = 32'h0;
    pipe.next_program_counter_in = 32'h0;
  endtask

  task automatic drive_instr(input logic exc, input logic [1:0] cause, input logic [2:0] funct3,
                             input logic is_load, input logic writes_rd, input logic [4:0] rd,
                             input logic [31:0] data, input logic [31:0] addr, input logic [31:0] pc);
    pipe.status_forwards_in      = {cause, exc, 1'b1};
    pipe.rd_data_in              = data;
    pipe.source_data_in          = addr;
    pipe.instruction_in          = '0;
    pipe.instruction_in[4:0]     = rd;
    pipe.instruction_in[5]       = writes_rd;
    pipe.instruction_in[6]       = is_load;
    pipe.instruction_in[9:7]     = funct3;
    pipe.program_counter_in      = pc;
    pipe.next_program_counter_in = pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_instret = 64'h0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_instret = 64'h0;
    rst = 1'b1;
    drive_idle();
    pipe_s.status_forwards_in      = 4'b0000;
    pipe_s.rd_data_in              = 32'h0;
    pipe_s.source_data_in          = 32'h0;
    pipe_s.instruction_in          = '0;
    pipe_s.program_counter_in      = 32'h0;
    pipe_s.next_program_counter_in = 32'h0;

    //             f3     ld    wr    rd     raw            off    we    data
    vecs[0]  = '{3'b000, 1'b1, 1'b1, 5'd5,  32'h80FF_7F01, 2'd3, 1'b1, 32'hFFFF_FF80};
    vecs[1]  = '{3'b100, 1'b1, 1'b1, 5'd6,  32'h80FF_7F01, 2'd2, 1'b1, 32'h0000_00FF};
    vecs[2]  = '{3'b001, 1'b1, 1'b1, 5'd7,  32'h80FF_7F01, 2'd2, 1'b1, 32'hFFFF_80FF};
    vecs[3]  = '{3'b101, 1'b1, 1'b1, 5'd8,  32'h80FF_7F01, 2'd0, 1'b1, 32'h0000_7F01};
    vecs[4]  = '{3'b010, 1'b1, 1'b1, 5'd9,  32'h80FF_7F01, 2'd0, 1'b1, 32'h80FF_7F01};
    vecs[5]  = '{3'b000, 1'b1, 1'b1, 5'd10, 32'h80FF_7F01, 2'd0, 1'b1, 32'h0000_0001};
    vecs[6]  = '{3'b000, 1'b1, 1'b1, 5'd11, 32'h80FF_7F01, 2'd1, 1'b1, 32'h0000_007F};
    vecs[7]  = '{3'b001, 1'b1, 1'b1, 5'd12, 32'h80FF_7F01, 2'd0, 1'b1, 32'h0000_7F01};
    vecs[8]  = '{3'b011, 1'b1, 1'b1, 5'd13, 32'h80FF_7F01, 2'd0, 1'b1, 32'h80FF_7F01};
    vecs[9]  = '{3'b000, 1'b0, 1'b1, 5'd0,  32'h0000_1234, 2'd3, 1'b0, 32'h0000_1234};
    vecs[10] = '{3'b000, 1'b0, 1'b0, 5'd14, 32'hCAFE_0000, 2'd1, 1'b0, 32'hCAFE_0000};

    do_reset();
    check("reset_rf_we", rf_we, 0);
    check("reset_fwd", forwarding_out, 0);
    check("reset_status", pipe.status_backwards_out, 2'b01);
    check("reset_jump", jump_addr, 0);
    check("reset_mepc", mepc, 0);
    check("reset_mcause", mcause, 0);
    check("reset_cycle", cycle_cnt, 0);
    check("reset_instret", instret_cnt, 0);

    for (int i = 0; i < 11; i++) begin
      drive_instr(1'b0, 2'b00, vecs[i].funct3, vecs[i].is_load, vecs[i].writes_rd, vecs[i].rd,
                  vecs[i].raw, {30'h100, vecs[i].off}, 32'h1000 + 32'(i * 4));
      step();
      exp_instret = exp_instret + 64'd1;
      check($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_we);
      check($sformatf("vec%0d_addr", i), rf_rd_addr, vecs[i].rd);
      check($sformatf("vec%0d_data", i), rf_rd_data, vecs[i].exp_data);
      check($sformatf("vec%0d_fwd", i), forwarding_out, {vecs[i].exp_we, vecs[i].rd, vecs[i].exp_data});
      check($sformatf("vec%0d_instret", i), instret_cnt, exp_instret);
    end

    // Idle cycle: write enable drops, address/data hold.
    drive_idle();
    step();
    check("idle_rf_we", rf_we, 0);
    check("idle_addr_hold", rf_rd_addr, 5'd14);
    check("idle_data_hold", rf_rd_data, 32'hCAFE_0000);
    check("idle_instret", instret_cnt, exp_instret);

    // Back-to-back ALU writes to rd=1,2,3.
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("b2b%0d_ready", i), pipe.status_backwards_out, 2'b01);
      drive_instr(1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 5'(i), 32'h0000_1111 * 32'(i), 32'h0, 32'h2000);
      step();
      exp_instret = exp_instret + 64'd1;
      check($sformatf("b2b%0d_rf_we", i), rf_we, 1);
      check($sformatf("b2b%0d_addr", i), rf_rd_addr, 5'(i));
      check($sformatf("b2b%0d_data", i), rf_rd_data, 32'h0000_1111 * 32'(i));
    end
    check("b2b_instret", instret_cnt, exp_instret);
    drive_idle();
    step();
    check("b2b_end_rf_we", rf_we, 0);

    // Trap with cause 2 at pc 0x40, then a valid instruction offered during TRAP.
    drive_instr(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 5'd4, 32'hDEAD_BEEF, 32'h0, 32'h40);
    step();
    check("trap_status", pipe.status_backwards_out, 2'b10);
    check("trap_jump", jump_addr, 32'h100);
    check("trap_mepc", mepc, 32'h40);
    check("trap_mcause", mcause, 2'b10);
    check("trap_rf_we", rf_we, 0);
    check("trap_instret", instret_cnt, exp_instret);
    drive_instr(1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 5'd9, 32'h5555_5555, 32'h0, 32'h44);
    step();
    check("post_trap_status", pipe.status_backwards_out, 2'b01);
    check("post_trap_jump", jump_addr, 0);
    check("flushed_rf_we", rf_we, 0);
    check("flushed_instret", instret_cnt, exp_instret);
    check("flushed_addr_hold", rf_rd_addr, 5'd3);
    drive_idle();
    step();
    check("trap_mepc_hold", mepc, 32'h40);

    // Reset while in TRAP.
    drive_instr(1'b1, 2'b01, 3'b000, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h80);
    step();
    drive_idle();
    check("trap2_status", pipe.status_backwards_out, 2'b10);
    check("trap2_mepc", mepc, 32'h80);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_instret = 64'h0;
    check("rst_trap_status", pipe.status_backwards_out, 2'b01);
    check("rst_trap_mepc", mepc, 0);
    check("rst_trap_mcause", mcause, 0);
    check("rst_trap_jump", jump_addr, 0);
    check("rst_trap_cycle", cycle_cnt, 0);
    check("rst_trap_instret", instret_cnt, 0);

    // Cycle counter from reset; the 4-bit instance wraps after 16 cycles.
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("cycle15", cycle_cnt, 64'd15);
    check("small_cycle15", s_cycle_cnt, 4'd15);
    step();
    check("cycle16", cycle_cnt, 64'd16);
    check("small_cycle_wrap", s_cycle_cnt, 4'd0);
    check("small_instret", s_instret_cnt, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
